spi_slave_regs: RTL

- SPI mode-0 responder: the target end of the 12-bit command / 8-bit read-data SPI link driven by the team's SPI master.
- Decodes write and read command frames from an external master.
- Backs the frames with an internal register bank of 2^ADDR_WIDTH bytes.
- Exposes write/read event strobes and a local read port to on-chip logic. All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_slave_regs.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 responder decoding 12-bit write/read frames into a byte register bank.
module spi_slave_regs #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  wr_vld,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_vld,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  frame_err,
  input  logic [ADDR_WIDTH-1:0] loc_addr,
  output logic [DATA_WIDTH-1:0] loc_data
);
  localparam int BW = $clog2(CMD_WIDTH);
  localparam int RW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] CMD_LAST = BW'(CMD_WIDTH - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CMD, RDATA, WAIT_CS} state_t;
  state_t                  state_q;
  logic [2:0]              sclk_q, cs_q;
  logic [1:0]              mosi_q;
  logic                    rise_q, fall_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [RW-1:0]           rd_cnt_q;
  logic [CMD_WIDTH-2:0]    cmd_sr_q;
  logic [DATA_WIDTH-1:0]   tx_sr_q;
  logic [DATA_WIDTH-1:0]   bank_q [2**ADDR_WIDTH];
  logic [CMD_WIDTH-1:0]    cmd_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic                    cs_start, cs_end;
  assign cs_start = ~cs_q[1] & cs_q[2];
  assign cs_end   = cs_q[1] & ~cs_q[2];
  assign cmd_d    = {cmd_sr_q, mosi_q[1]};
  assign cmd_addr = cmd_d[CMD_WIDTH-2 -: ADDR_WIDTH];
  assign cmd_data = cmd_d[DATA_WIDTH-1:0];
  // Derived from state so an abort releases the pad in the same cycle it leaves RDATA.
  assign miso_oe  = state_q == RDATA;
  assign miso     = miso_oe & tx_sr_q[DATA_WIDTH-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sclk_q    <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      bit_cnt_q <= '0;
      rd_cnt_q  <= '0;
      cmd_sr_q  <= '0;
      tx_sr_q   <= '0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
      loc_data  <= '0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) bank_q[i] <= '0;
    end else begin
      sclk_q    <= {sclk_q[1:0], sclk};
      cs_q      <= {cs_q[1:0], cs};
      mosi_q    <= {mosi_q[0], mosi};
      rise_q    <= sclk_q[1] & ~sclk_q[2];
      fall_q    <= ~sclk_q[1] & sclk_q[2];
      wr_vld    <= 1'b0;
      rd_vld    <= 1'b0;
      frame_err <= 1'b0;
      loc_data  <= bank_q[loc_addr];
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          cmd_sr_q  <= '0;
          if (cs_start) state_q <= CMD;
        end
        CMD: begin
          if (cs_end) begin
            state_q   <= IDLE;
            frame_err <= 1'b1;
          end else if (rise_q) begin
            cmd_sr_q  <= cmd_d[CMD_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CMD_LAST && cmd_d[CMD_WIDTH-1]) begin
              bank_q[cmd_addr] <= cmd_data;
              wr_vld           <= 1'b1;
              wr_addr          <= cmd_addr;
              wr_data          <= cmd_data;
              state_q          <= WAIT_CS;
            end else if (bit_cnt_q == CMD_LAST) begin
              tx_sr_q  <= bank_q[cmd_addr];
              rd_addr  <= cmd_addr;
              rd_cnt_q <= '0;
              state_q  <= RDATA;
            end
          end
        end
        RDATA: begin
          if (cs_end) begin
            state_q   <= IDLE;
            frame_err <= 1'b1;
          end else begin
            if (rise_q) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rise_q && rd_cnt_q == RD_LAST) begin
              rd_vld  <= 1'b1;
              state_q <= WAIT_CS;
            end
            // The first read bit is already on miso when RDATA is entered, so skip the first fall.
            if (fall_q && rd_cnt_q != '0) tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: if (cs_end) state_q <= IDLE;
      endcase
    end
  end
endmodule
